// File: rtl/data_mem_pkg.sv
// Shared encodings and parameter defaults for the data-memory load/store unit.
package data_mem_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 129;
  localparam int unsigned AW_DEFAULT        = 9;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/data_mem_lane_align.sv
// Combinational lane logic: request legality check, load extract/extend, store merge.
module data_mem_lane_align
  import data_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int unsigned AW        = AW_DEFAULT
) (
  input  logic [1:0]    chk_size_i,
  input  logic [AW+1:0] chk_addr_i,
  output logic          chk_error_o,
  input  logic [1:0]    size_i,
  input  logic [1:0]    offset_i,
  input  logic          signed_i,
  input  logic [31:0]   rd_word_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   load_data_o,
  output logic [31:0]   store_word_o
);

  localparam logic [AW:0] WORD_LIMIT = (AW+1)'(MEM_WORDS);

  logic [4:0]  shamt;
  logic [31:0] lane;
  logic [31:0] mask;

  assign shamt = {offset_i, 3'b000};
  assign lane  = rd_word_i >> shamt;

  always_comb begin
    chk_error_o = 1'b0;
    case (size_e'(chk_size_i))
      SIZE_BYTE: chk_error_o = 1'b0;
      SIZE_HALF: chk_error_o = chk_addr_i[0];
      SIZE_WORD: chk_error_o = |chk_addr_i[1:0];
      default:   chk_error_o = 1'b1;
    endcase
    if ({1'b0, chk_addr_i[AW+1:2]} >= WORD_LIMIT) chk_error_o = 1'b1;
  end

  // Word accesses are always at offset 0, so the shifted lane is the whole word.
  always_comb begin
    load_data_o = lane;
    mask        = '1;
    case (size_e'(size_i))
      SIZE_BYTE: begin
        load_data_o = {{24{signed_i & lane[7]}}, lane[7:0]};
        mask        = 32'h0000_00FF << shamt;
      end
      SIZE_HALF: begin
        load_data_o = {{16{signed_i & lane[15]}}, lane[15:0]};
        mask        = 32'h0000_FFFF << shamt;
      end
      default: ;
    endcase
    store_word_o = (rd_word_i & ~mask) | ((wdata_i << shamt) & mask);
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store initiator for the word-addressed data memory: one request in flight,
// sub-word stores done as read-modify-write.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int unsigned AW        = AW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW+1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_error,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [31:0]   mem_rd_data,
  output logic [AW-1:0] mem_wr_addr,
  output logic [31:0]   mem_wr_data,
  output logic          mem_wr_enable
);

  state_e        state_q, state_d;
  logic          ready_q;
  logic          write_q, write_d;
  logic [1:0]    size_q, size_d;
  logic          signed_q, signed_d;
  logic [1:0]    offset_q, offset_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          error_q, error_d;

  logic          chk_error;
  logic [31:0]   load_data;
  logic [31:0]   store_word;
  logic          accept;

  data_mem_lane_align #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_align (
    .chk_size_i   (req_size),
    .chk_addr_i   (req_addr),
    .chk_error_o  (chk_error),
    .size_i       (size_q),
    .offset_i     (offset_q),
    .signed_i     (signed_q),
    .rd_word_i    (mem_rd_data),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  assign req_ready     = ready_q && (state_q == ST_IDLE);
  assign accept        = req_valid && req_ready;
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_error     = error_q;
  assign mem_rd_addr   = rd_addr_q;
  assign mem_wr_addr   = wr_addr_q;
  assign mem_wr_data   = wr_data_q;
  assign mem_wr_enable = (state_q == ST_WRITE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      write_q   <= 1'b0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      offset_q  <= '0;
      wdata_q   <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= 1'b1;
      write_q   <= write_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      offset_q  <= offset_d;
      wdata_q   <= wdata_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    size_d    = size_q;
    signed_d  = signed_q;
    offset_d  = offset_q;
    wdata_d   = wdata_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          offset_d = req_addr[1:0];
          wdata_d  = req_wdata;
          rdata_d  = '0;
          error_d  = chk_error;
          if (chk_error) begin
            state_d = ST_RESP;
          end else begin
            rd_addr_d = req_addr[AW+1:2];
            state_d   = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // The word buffer is captured already merged, so WRITE only drives the strobe.
        if (write_q) begin
          wr_addr_d = rd_addr_q;
          wr_data_d = store_word;
          state_d   = ST_WRITE;
        end else begin
          rdata_d = load_data;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
